// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one uart_tx among NUM_REQ byte clients,
// with an idle timeout that drops the lock when the owner stalls mid-packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {ARB, FETCH, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [PW-1:0] ptr, pick, idx;
    logic          hit, last_flag;
    logic [CW-1:0] cnt;

    assign req_ready = (state == FETCH) ? (grant & {NUM_REQ{tx_ready}}) : '0;

    // Descending scan so the candidate closest after ptr wins.
    always_comb begin
        hit  = 1'b0;
        pick = ptr;
        idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    // The pointer doubles as the index of the current owner while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            grant     <= '0;
            busy      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            last_flag <= 1'b0;
            cnt       <= '0;
            ptr       <= PW'(NUM_REQ - 1);
        end else begin
            case (state)
                ARB: if (hit) begin
                    grant <= NUM_REQ'(1) << pick;
                    busy  <= 1'b1;
                    ptr   <= pick;
                    cnt   <= '0;
                    state <= FETCH;
                end
                FETCH: if (tx_ready) begin
                    if (req_valid[ptr]) begin
                        tx_data   <= req_data[{ptr, 3'b000} +: 8];
                        last_flag <= req_last[ptr];
                        tx_valid  <= 1'b1;
                        cnt       <= '0;
                        state     <= SEND;
                    end else if (IDLE_TIMEOUT != 0 && cnt == CW'(IDLE_TIMEOUT - 1)) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ARB;
                    end else if (IDLE_TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    tx_valid <= 1'b0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (!tx_ready) state <= WAIT_DONE;
                WAIT_DONE: if (tx_ready) begin
                    if (last_flag) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ARB;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a uart_tx model at 8 cycles/bit (80-cycle frames).
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, grant;
    logic        busy, tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        m_ready = 1'b1;
    logic        hold = 1'b0;
    int          bcnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;
    assign tx_ready = m_ready & ~hold;

    uart_tx_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    // uart_tx model: accepts a start pulse while idle, then stays busy for one frame.
    always @(posedge clk) begin
        if (bcnt == 0) begin
            if (tx_valid && tx_ready) begin
                bcnt    <= 80;
                m_ready <= 1'b0;
            end
        end else begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) m_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every start pulse must match the next expected {grant, byte}.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected got grant=%b data=%h", grant, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant, tx_data} !== e) begin
                        failures++;
                        $display("FAIL tx_byte got grant=%b data=%h exp grant=%b data=%h",
                                 grant, tx_data, e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic send(input int c, input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        req_valid[c] = 1'b1;
        req_data[c*8 +: 8] = d;
        req_last[c] = l;
        while (!req_ready[c] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout client=%0d got=not_ready exp=ready", c);
        end
        @(negedge clk);
        req_valid[c] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((grant != 0 || !tx_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got grant=%b exp grant=0000", grant);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic bad;
        // Single client two-byte packet
        do_reset();
        exp_q.push_back({4'b0010, 8'h55});
        exp_q.push_back({4'b0010, 8'hA3});
        send(1, 8'h55, 1'b0);
        chk("t1_grant_mid", 32'(grant), 32'b0010);
        chk("t1_busy_mid", 32'(busy), 1);
        send(1, 8'hA3, 1'b1);
        wait_idle();
        chk("t1_grant_end", 32'(grant), 0);
        chk("t1_busy_end", 32'(busy), 0);

        // Simultaneous clients 0 and 2, packets do not interleave
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back({4'b0001, 8'h01 + 8'(i)});
        for (int i = 0; i < 3; i++) exp_q.push_back({4'b0100, 8'hC1 + 8'(i)});
        fork
            begin
                send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); send(0, 8'h03, 1'b1);
            end
            begin
                send(2, 8'hC1, 1'b0); send(2, 8'hC2, 1'b0); send(2, 8'hC3, 1'b1);
            end
        join
        wait_idle();

        // All four clients, 1-byte packets, round robin
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) exp_q.push_back({4'(1 << c), 8'(8'h10 * (r + 1) + c)});
        fork
            begin send(0, 8'h10, 1'b1); send(0, 8'h20, 1'b1); end
            begin send(1, 8'h11, 1'b1); send(1, 8'h21, 1'b1); end
            begin send(2, 8'h12, 1'b1); send(2, 8'h22, 1'b1); end
            begin send(3, 8'h13, 1'b1); send(3, 8'h23, 1'b1); end
        join
        wait_idle();

        // Client 3 stalls mid-packet, client 1 waits for the timeout
        do_reset();
        exp_q.push_back({4'b1000, 8'h11});
        exp_q.push_back({4'b0010, 8'h77});
        send(3, 8'h11, 1'b0);
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h77;
        req_last[1] = 1'b1;
        n = 0;
        while (tx_ready && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_ready && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (grant == 4'b1000 && n < 100) begin n++; @(negedge clk); end
        chk("t4_timeout_cycles", 32'(n), 17);
        send(1, 8'h77, 1'b1);
        wait_idle();

        // tx_ready held low while client 0 owns the UART
        do_reset();
        hold = 1'b1;
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h3C;
        req_last[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_grant", 32'(grant), 32'b0001);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != 0 || tx_valid) bad = 1'b1;
        end
        chk("t5_no_xfer", 32'(bad), 0);
        req_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_timeout", 32'(grant), 32'b0001);
        exp_q.push_back({4'b0001, 8'h3C});
        hold = 1'b0;
        send(0, 8'h3C, 1'b1);
        wait_idle();

        // Reset during WAIT_DONE of a two-byte packet
        do_reset();
        exp_q.push_back({4'b0100, 8'h81});
        send(2, 8'h81, 1'b0);
        n = 0;
        while (tx_ready && n < 200) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("t6_grant_pre", 32'(grant), 32'b0100);
        #2 rst = 1'b1;
        #1;
        chk("t6_grant_async", 32'(grant), 0);
        chk("t6_busy_async", 32'(busy), 0);
        chk("t6_tx_valid_async", 32'(tx_valid), 0);
        chk("t6_req_ready_async", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("t6_grant_after", 32'(grant), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
